// File: rtl/ft245_device_if.sv
// FT245 synchronous FIFO signal bundle: master-side strobes, device-side flags and the host FIFO ports.
// The bidirectional data bus ft_bus is kept as a plain top-level inout so tristate resolution stays at module ports.
//
// Handshake semantics (all sampled on the rising edge of ft_clkout):
//   FT read  : a byte transfers on an edge where ft_rd_n==0 && ft_oe_n==0 && ft_rxf_n==0 (ft_rxf_n is the valid).
//   FT write : a byte transfers on an edge where ft_wr_n==0 && ft_txe_n==0 && ft_oe_n==1 (ft_txe_n is the not-ready).
//   Host push: a byte transfers on an edge where host_winc==1 && host_wfull==0 (a same-edge FT pop also frees a slot).
//   Host pop : a byte transfers on an edge where host_rinc==1 && host_rempty==0; host_rdata is the head byte.
interface ft245_device_if;
  logic       ft_rxf_n;
  logic       ft_txe_n;
  logic       ft_rd_n;
  logic       ft_wr_n;
  logic       ft_oe_n;
  logic       ft_siwu_n;
  logic [7:0] host_wdata;
  logic       host_winc;
  logic       host_wfull;
  logic [7:0] host_rdata;
  logic       host_rinc;
  logic       host_rempty;
  logic       proto_err;

  modport slave (
    output ft_rxf_n, ft_txe_n, host_wfull, host_rdata, host_rempty, proto_err,
    input  ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n, host_wdata, host_winc, host_rinc
  );

  modport master (
    input  ft_rxf_n, ft_txe_n, host_wfull, host_rdata, host_rempty, proto_err,
    output ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n, host_wdata, host_winc, host_rinc
  );
endinterface

// File: rtl/ft245_device.sv
// Device-side (FTDI end) model of the synchronous FT245 FIFO: DOWN FIFO (host -> master) and UP FIFO (master -> host).
// Build option FT245_DEVICE_LOOPBACK_EN: UP FIFO removed, master writes loop back into the DOWN FIFO.
module ft245_device #(
  parameter int DOWN_AW = 4,
  parameter int UP_AW   = 4
) (
  input  logic          ft_clkout,
  input  logic          rst_n,
  inout  wire  [7:0]    ft_bus,
  ft245_device_if.slave ft
);

  localparam int DOWN_DEPTH = 1 << DOWN_AW;

  logic ft_rd_ok;
  logic ft_wr_ok;
  logic err_now;

  // Legal strobes only; an offending strobe never touches a FIFO.
  assign ft_rd_ok = !ft.ft_rd_n && !ft.ft_oe_n && !ft.ft_rxf_n;
  assign ft_wr_ok = !ft.ft_wr_n && !ft.ft_txe_n && ft.ft_oe_n;
  assign err_now  = (!ft.ft_rd_n && (ft.ft_oe_n || ft.ft_rxf_n)) ||
                    (!ft.ft_wr_n && (ft.ft_txe_n || !ft.ft_oe_n));

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      ft.proto_err <= 1'b0;
    end else if (err_now) begin
      ft.proto_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- DOWN FIFO
  logic [7:0]         down_mem [DOWN_DEPTH];
  logic [DOWN_AW-1:0] down_wptr;
  logic [DOWN_AW-1:0] down_rptr;
  logic [DOWN_AW:0]   down_count;
  logic [DOWN_AW:0]   down_count_next;
  logic               down_push;
  logic               down_pop;
  logic [7:0]         down_wdata;

  assign down_pop = ft_rd_ok;

`ifdef FT245_DEVICE_LOOPBACK_EN
  assign down_push  = ft_wr_ok;
  assign down_wdata = ft_bus;
`else
  // A same-edge FT pop frees a slot, so a push against a full FIFO still lands.
  assign down_push  = ft.host_winc && (!ft.host_wfull || ft_rd_ok);
  assign down_wdata = ft.host_wdata;
`endif

  always_comb begin
    down_count_next = down_count;
    if (down_push && !down_pop) begin
      down_count_next = down_count + (DOWN_AW+1)'(1);
    end else if (down_pop && !down_push) begin
      down_count_next = down_count - (DOWN_AW+1)'(1);
    end
  end

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      down_wptr   <= '0;
      down_rptr   <= '0;
      down_count  <= '0;
      ft.ft_rxf_n <= 1'b1;
`ifdef FT245_DEVICE_LOOPBACK_EN
      ft.ft_txe_n <= 1'b1;
`else
      ft.host_wfull <= 1'b0;
`endif
    end else begin
      if (down_push) begin
        down_wptr <= down_wptr + DOWN_AW'(1);
      end
      if (down_pop) begin
        down_rptr <= down_rptr + DOWN_AW'(1);
      end
      down_count  <= down_count_next;
      ft.ft_rxf_n <= (down_count_next == '0);
`ifdef FT245_DEVICE_LOOPBACK_EN
      ft.ft_txe_n <= (down_count_next == (DOWN_AW+1)'(DOWN_DEPTH));
`else
      ft.host_wfull <= (down_count_next == (DOWN_AW+1)'(DOWN_DEPTH));
`endif
    end
  end

  always_ff @(posedge ft_clkout) begin
    if (down_push) begin
      down_mem[down_wptr] <= down_wdata;
    end
  end

  // Head byte is presented straight from the registered read pointer.
  assign ft_bus = ft.ft_oe_n ? 8'hzz : down_mem[down_rptr];

`ifdef FT245_DEVICE_LOOPBACK_EN
  // ---------------------------------------------------------------- loopback ties
  assign ft.host_wfull  = 1'b1;
  assign ft.host_rempty = 1'b1;
  assign ft.host_rdata  = 8'h00;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ft.ft_siwu_n, ft.host_winc, ft.host_rinc, ft.host_wdata};
`else
  // ---------------------------------------------------------------- UP FIFO
  localparam int UP_DEPTH = 1 << UP_AW;

  logic [7:0]       up_mem [UP_DEPTH];
  logic [UP_AW-1:0] up_wptr;
  logic [UP_AW-1:0] up_rptr;
  logic [UP_AW:0]   up_count;
  logic [UP_AW:0]   up_count_next;
  logic             up_push;
  logic             up_pop;

  assign up_push = ft_wr_ok;
  assign up_pop  = ft.host_rinc && !ft.host_rempty;

  always_comb begin
    up_count_next = up_count;
    if (up_push && !up_pop) begin
      up_count_next = up_count + (UP_AW+1)'(1);
    end else if (up_pop && !up_push) begin
      up_count_next = up_count - (UP_AW+1)'(1);
    end
  end

  always_ff @(posedge ft_clkout or negedge rst_n) begin
    if (!rst_n) begin
      up_wptr        <= '0;
      up_rptr        <= '0;
      up_count       <= '0;
      ft.ft_txe_n    <= 1'b1;
      ft.host_rempty <= 1'b1;
    end else begin
      if (up_push) begin
        up_wptr <= up_wptr + UP_AW'(1);
      end
      if (up_pop) begin
        up_rptr <= up_rptr + UP_AW'(1);
      end
      up_count       <= up_count_next;
      ft.ft_txe_n    <= (up_count_next == (UP_AW+1)'(UP_DEPTH));
      ft.host_rempty <= (up_count_next == '0);
    end
  end

  always_ff @(posedge ft_clkout) begin
    if (up_push) begin
      up_mem[up_wptr] <= ft_bus;
    end
  end

  assign ft.host_rdata = up_mem[up_rptr];

  // Send-immediate is accepted on the pin but has no effect on this model.
  logic unused_siwu;
  assign unused_siwu = ft.ft_siwu_n;
`endif

endmodule

// File: tb/tb_ft245_device.sv
// Self-checking bench for ft245_device: directed steps plus random traffic against a queue-based reference model.
// Honours FT245_DEVICE_LOOPBACK_EN so the same bench covers both builds.
module tb_ft245_device;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       drive_en;
  logic [7:0] drive_val;
  wire  [7:0] ft_bus;

  int checks = 0;
  int errors = 0;

  logic [7:0] down_q[$];
  logic [7:0] up_q[$];
  logic       err_m;

  ft245_device_if ifc ();

  ft245_device #(.DOWN_AW(4), .UP_AW(4)) dut (
    .ft_clkout (clk),
    .rst_n     (rst_n),
    .ft_bus    (ft_bus),
    .ft        (ifc.slave)
  );

  // Master side drives the bus only for writes; a released bus floats high through the pullup.
  assign ft_bus = drive_en ? drive_val : 8'hzz;
  pullup (ft_bus);

  // ---------------------------------------------------------------- clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit txe_full_m();
`ifdef FT245_DEVICE_LOOPBACK_EN
    return down_q.size() == DEPTH;
`else
    return up_q.size() == DEPTH;
`endif
  endfunction

  task automatic check_outputs();
    chk("rxf_n", ifc.ft_rxf_n, 8'(down_q.size() == 0));
    chk("txe_n", ifc.ft_txe_n, 8'(txe_full_m()));
    chk("proto_err", ifc.proto_err, 8'(err_m));
`ifdef FT245_DEVICE_LOOPBACK_EN
    chk("lb_wfull", ifc.host_wfull, 8'h01);
    chk("lb_rempty", ifc.host_rempty, 8'h01);
    chk("lb_rdata", ifc.host_rdata, 8'h00);
`else
    chk("wfull", ifc.host_wfull, 8'(down_q.size() == DEPTH));
    chk("rempty", ifc.host_rempty, 8'(up_q.size() == 0));
    if (up_q.size() != 0) chk("rdata", ifc.host_rdata, up_q[0]);
`endif
    if (!ifc.ft_oe_n && down_q.size() != 0) chk("bus_head", ft_bus, down_q[0]);
    else if (ifc.ft_oe_n && !drive_en) chk("bus_z", ft_bus, 8'hFF);
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic idle();
    ifc.ft_rd_n    = 1'b1;
    ifc.ft_wr_n    = 1'b1;
    ifc.ft_oe_n    = 1'b1;
    ifc.ft_siwu_n  = 1'b1;
    ifc.host_winc  = 1'b0;
    ifc.host_rinc  = 1'b0;
    ifc.host_wdata = 8'h00;
    drive_en       = 1'b0;
    drive_val      = 8'h00;
  endtask

  // One clock: the model applies the transfers the current inputs request, then outputs are checked.
  task automatic step();
    int         dn;
    int         up;
    bit         rd_ok;
    bit         wr_ok;
    bit         hpush;
    bit         hpop;
    bit         tfull;
    logic [7:0] bus_w;
    logic [7:0] host_w;
    dn     = down_q.size();
    up     = up_q.size();
    tfull  = txe_full_m();
    bus_w  = drive_val;
    host_w = ifc.host_wdata;
    rd_ok  = !ifc.ft_rd_n && !ifc.ft_oe_n && dn != 0;
    wr_ok  = !ifc.ft_wr_n && ifc.ft_oe_n && !tfull;
`ifdef FT245_DEVICE_LOOPBACK_EN
    hpush = 1'b0;
    hpop  = 1'b0;
`else
    hpush = ifc.host_winc && (dn != DEPTH || rd_ok);
    hpop  = ifc.host_rinc && up != 0;
`endif
    if ((!ifc.ft_rd_n && (ifc.ft_oe_n || dn == 0)) || (!ifc.ft_wr_n && (tfull || !ifc.ft_oe_n)))
      err_m = 1'b1;
    @(posedge clk);
    if (rd_ok) void'(down_q.pop_front());
    if (hpush) down_q.push_back(host_w);
`ifdef FT245_DEVICE_LOOPBACK_EN
    if (wr_ok) down_q.push_back(bus_w);
`else
    if (wr_ok) up_q.push_back(bus_w);
`endif
    if (hpop) void'(up_q.pop_front());
    #1;
    check_outputs();
  endtask

  // Asserts reset away from the clock edge; flags must fall to reset values without waiting for an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    down_q.delete();
    up_q.delete();
    err_m = 1'b0;
    #1;
    chk("rst_rxf_n", ifc.ft_rxf_n, 8'h01);
    chk("rst_txe_n", ifc.ft_txe_n, 8'h01);
    chk("rst_rempty", ifc.host_rempty, 8'h01);
    chk("rst_proto_err", ifc.proto_err, 8'h00);
`ifdef FT245_DEVICE_LOOPBACK_EN
    chk("rst_wfull", ifc.host_wfull, 8'h01);
`else
    chk("rst_wfull", ifc.host_wfull, 8'h00);
`endif
    idle();
    #1;
    chk("rst_bus_z", ft_bus, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] pat3 [3];
    pat3 = '{8'h11, 8'h22, 8'h33};
    rst_n = 1'b1;
    err_m = 1'b0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    step();
    chk("rel_txe_n", ifc.ft_txe_n, 8'h00);
    chk("rel_rxf_n", ifc.ft_rxf_n, 8'h01);

`ifdef FT245_DEVICE_LOOPBACK_EN
    ifc.ft_wr_n = 1'b0;
    drive_en    = 1'b1;
    drive_val   = 8'hA5;
    step();
    chk("lb_rxf_low", ifc.ft_rxf_n, 8'h00);
    drive_val = 8'h5A;
    step();
    idle();
    ifc.ft_oe_n = 1'b0;
    step();
    chk("lb_rd0", ft_bus, 8'hA5);
    ifc.ft_rd_n = 1'b0;
    step();
    chk("lb_rd1", ft_bus, 8'h5A);
    step();
    chk("lb_rd_end", ifc.ft_rxf_n, 8'h01);
    idle();
    step();
`else
    // Host pushes three bytes, master holds OE# two cycles and then reads them.
    for (int i = 0; i < 3; i++) begin
      ifc.host_winc  = 1'b1;
      ifc.host_wdata = pat3[i];
      step();
    end
    idle();
    ifc.ft_oe_n = 1'b0;
    step();
    step();
    ifc.ft_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_bus", ft_bus, pat3[i]);
      step();
    end
    chk("rd_end_rxf_n", ifc.ft_rxf_n, 8'h01);
    idle();
    step();

    // Fill UP with 16 bytes; the 17th strobe is a violation.
    ifc.ft_wr_n = 1'b0;
    drive_en    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_val = 8'(i);
      step();
    end
    chk("wr16_txe_n", ifc.ft_txe_n, 8'h01);
    chk("wr16_rdata", ifc.host_rdata, 8'h00);
    drive_val = 8'h10;
    step();
    chk("wr17_err", ifc.proto_err, 8'h01);
    do_reset();
    step();

    // Host drains UP while the master streams a byte every cycle.
    ifc.host_rinc = 1'b1;
    ifc.ft_wr_n   = 1'b0;
    drive_en      = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive_val = 8'(i);
      step();
      chk("stream_txe_n", ifc.ft_txe_n, 8'h00);
    end
    ifc.ft_wr_n = 1'b1;
    drive_en    = 1'b0;
    step();
    step();
    chk("stream_empty", ifc.host_rempty, 8'h01);
    idle();

    // Each kind of protocol violation sets the sticky flag.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      step();
      case (k)
        0:       begin ifc.ft_rd_n = 1'b0; ifc.ft_oe_n = 1'b1; end
        1:       begin ifc.ft_rd_n = 1'b0; ifc.ft_oe_n = 1'b0; end
        default: begin ifc.ft_wr_n = 1'b0; ifc.ft_oe_n = 1'b0; end
      endcase
      step();
      chk("perr_set", ifc.proto_err, 8'h01);
      idle();
      step();
      chk("perr_sticky", ifc.proto_err, 8'h01);
    end

    // Reset in the middle of a read burst.
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      ifc.host_winc  = 1'b1;
      ifc.host_wdata = 8'h40 + 8'(i);
      step();
    end
    idle();
    ifc.ft_oe_n = 1'b0;
    step();
    ifc.ft_rd_n = 1'b0;
    step();
    step();
    do_reset();
    step();
    chk("midrst_rxf_n", ifc.ft_rxf_n, 8'h01);
`endif

    // Random legal traffic from both sides.
    do_reset();
    step();
    for (int n = 0; n < 300; n++) begin
      int r;
      idle();
      r              = int'($urandom_range(0, 3));
      ifc.ft_siwu_n  = 1'($urandom_range(0, 1));
      ifc.host_winc  = ($urandom_range(0, 3) != 0);
      ifc.host_wdata = 8'($urandom);
      ifc.host_rinc  = 1'($urandom_range(0, 1));
      case (r)
        1: ifc.ft_oe_n = 1'b0;
        2: begin
          ifc.ft_oe_n = 1'b0;
          if (down_q.size() != 0) ifc.ft_rd_n = 1'b0;
        end
        3: if (!txe_full_m()) begin
          ifc.ft_wr_n = 1'b0;
          drive_en    = 1'b1;
          drive_val   = 8'($urandom);
        end
        default: ;
      endcase
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
